// File: rtl/mix_pkg.sv
// Shared widths, constant tables and enums for the mix sequencer.
// Both the register-file owner and the combinational word ALU import this.
package mix_pkg;
  localparam int WIDTH  = 32;
  localparam int NWORDS = 8;

  typedef logic [WIDTH-1:0]            word_t;
  typedef logic [$clog2(NWORDS)-1:0]   idx_t;
  typedef word_t [NWORDS-1:0]          regfile_t;

  localparam word_t MA [NWORDS] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  localparam word_t CA [NWORDS] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
  localparam word_t MB [NWORDS] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
  localparam word_t CB [NWORDS] = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343};

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_e;
  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} stage_e;
endpackage

// File: rtl/mix_word_alu.sv
// Combinational single-word update: new o[idx] for the given stage,
// reading the live register file so earlier updates in a stage are visible.
module mix_word_alu
  import mix_pkg::*;
(
  input  stage_e   stage,
  input  idx_t     idx,
  input  regfile_t o,
  output word_t    result
);
  idx_t  ip1, ip2, ip3, ip4, ip5, im1, im2;
  word_t cur;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ip1    = idx + idx_t'(1);
    ip2    = idx + idx_t'(2);
    ip3    = idx + idx_t'(3);
    ip4    = idx + idx_t'(4);
    ip5    = idx + idx_t'(5);
    im1    = idx - idx_t'(1);
    im2    = idx - idx_t'(2);
    cur    = o[idx];
    result = cur;
    case (stage)
      S0: result = cur + word_t'(idx);
      S1: result = cur + o[im1];
      S2: result = cur + o[ip1] - o[ip5];
      S3: result = cur ^ (o[ip3] << 16);
      S4: result = cur - (o[ip2] >> 17) + (o[ip4] >> 12);
      S5: result = cur + o[im1] - o[im2];
      S6: result = cur * MA[idx] + CA[idx];
      S7: result = cur * MB[idx] + CB[idx];
      default: result = cur;
    endcase
  end
endmodule

// File: rtl/mix_sequencer.sv
// Loads eight seed words, runs 64 in-place word updates per pass,
// then streams the eight result words out with valid/ready handshakes.
module mix_sequencer
  import mix_pkg::*;
#(
  parameter int PASSES_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [PASSES_W-1:0] cfg_passes,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_last,
  output logic                busy
);
  state_e              state_q, state_d;
  idx_t                word_q, word_d;
  idx_t                stage_q, stage_d;
  logic [PASSES_W-1:0] pass_q, pass_d;
  logic [PASSES_W-1:0] passes_q, passes_d;
  regfile_t            regs_q, regs_d;
  word_t               alu_out;
  stage_e              cur_stage;

  assign cur_stage = stage_e'(stage_q);
  assign busy      = (state_q != IDLE);

  mix_word_alu u_alu (
    .stage  (cur_stage),
    .idx    (word_q),
    .o      (regs_q),
    .result (alu_out)
  );

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    stage_d   = stage_q;
    pass_d    = pass_q;
    passes_d  = passes_q;
    regs_d    = regs_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state_q)
      IDLE, LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          regs_d[word_q] = in_data;
          word_d         = word_q + idx_t'(1);
          if (state_q == IDLE) begin
            state_d = LOAD;
          end else if (word_q == idx_t'(NWORDS - 1)) begin
            passes_d = cfg_passes;
            word_d   = '0;
            stage_d  = '0;
            pass_d   = '0;
            state_d  = (cfg_passes == '0) ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        regs_d[word_q] = alu_out;
        word_d         = word_q + idx_t'(1);
        if (word_q == idx_t'(NWORDS - 1)) begin
          stage_d = stage_q + idx_t'(1);
          if (stage_q == idx_t'(7)) begin
            pass_d = pass_q + PASSES_W'(1);
            // Word and stage counters both wrap to 0, ready for the drain.
            if (pass_q == passes_q - PASSES_W'(1)) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = regs_q[word_q];
        out_last  = (word_q == idx_t'(NWORDS - 1));
        if (out_ready) begin
          word_d = word_q + idx_t'(1);
          if (word_q == idx_t'(NWORDS - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      word_q   <= '0;
      stage_q  <= '0;
      pass_q   <= '0;
      passes_q <= '0;
      // NOTE: the register file is deliberately reset to o[i] = i, so it lives in flops, not RAM.
      for (int i = 0; i < NWORDS; i++) regs_q[i] <= word_t'(i);
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      stage_q  <= stage_d;
      pass_q   <= pass_d;
      passes_q <= passes_d;
      regs_q   <= regs_d;
    end
  end
endmodule

// File: tb/tb_mix_sequencer.sv
// Directed bench for mix_sequencer: echo, mixing passes, gapped load,
// backpressure, mid-run reset and in_valid held through RUN/DRAIN.
module tb_mix_sequencer;
  localparam int PW = 4;

  localparam logic [31:0] TB_MA [8] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  localparam logic [31:0] TB_CA [8] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
  localparam logic [31:0] TB_MB [8] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
  localparam logic [31:0] TB_CB [8] = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [31:0]   in_data, out_data;
  logic [PW-1:0] cfg_passes;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl      [8];
  logic [31:0] got      [8];
  logic        got_last [8];
  int          got_n;

  always #5 clk = ~clk;

  mix_sequencer #(.PASSES_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .cfg_passes (cfg_passes),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sequential in-place reference model working on mdl[].
  task automatic run_model(input int passes);
    logic [31:0] a, r;
    for (int p = 0; p < passes; p++)
      for (int s = 0; s < 8; s++)
        for (int i = 0; i < 8; i++) begin
          a = mdl[i];
          case (s)
            0: r = a + 32'(i);
            1: r = a + mdl[(i + 7) % 8];
            2: r = a + mdl[(i + 1) % 8] - mdl[(i + 5) % 8];
            3: r = a ^ (mdl[(i + 3) % 8] << 16);
            4: r = a - (mdl[(i + 2) % 8] >> 17) + (mdl[(i + 4) % 8] >> 12);
            5: r = a + mdl[(i + 7) % 8] - mdl[(i + 6) % 8];
            6: r = a * TB_MA[i] + TB_CA[i];
            default: r = a * TB_MB[i] + TB_CB[i];
          endcase
          mdl[i] = r;
        end
  endtask

  task automatic load_seeds(input logic [31:0] seeds [8], input logic [PW-1:0] passes,
                            input logic [PW-1:0] decoy, input bit gapped, input bit hold_valid);
    for (int k = 0; k < 8; k++) begin
      in_valid   = 1'b1;
      in_data    = seeds[k];
      cfg_passes = (k == 7) ? passes : decoy;
      tick();
      if (gapped && k < 7) begin
        in_valid   = 1'b0;
        in_data    = 32'hDEAD_0000 + 32'(k);
        cfg_passes = decoy;
        tick();
      end
    end
    in_valid   = hold_valid;
    in_data    = 32'hBAD0_BAD0;
    cfg_passes = decoy;
  endtask

  task automatic wait_run(output int cycles, input int limit);
    cycles = 0;
    while (!out_valid && cycles < limit) begin
      cycles++;
      tick();
    end
  endtask

  task automatic collect(input int limit);
    int c = 0;
    got_n     = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      got[i]      = 32'hFFFF_FFFF;
      got_last[i] = 1'bx;
    end
    while (got_n < 8 && c < limit) begin
      if (out_valid) begin
        got[got_n]      = out_data;
        got_last[got_n] = out_last;
        got_n++;
      end
      if (got_n < 8) begin
        tick();
        c++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_passes = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_idle: busy=%b in_ready=%b expected 0/1", busy, in_ready); end
  endtask

  task automatic test_passthrough();
    logic [31:0] seeds [8];
    for (int i = 0; i < 8; i++) seeds[i] = 32'hA0 + 32'(i);
    load_seeds(seeds, 4'd0, 4'd0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL echo_drain_entry: out_valid=%b busy=%b expected 1/1", out_valid, busy); end
    collect(40);
    checks++; if (got_n !== 8) begin errors++; $display("FAIL echo_count: got %0d expected 8", got_n); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== seeds[i]) begin errors++; $display("FAIL echo_word%0d: got %h expected %h", i, got[i], seeds[i]); end
      checks++; if (got_last[i] !== (i == 7)) begin errors++; $display("FAIL echo_last%0d: got %b expected %b", i, got_last[i], (i == 7)); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL echo_busy_at_last: got %b expected 1", busy); end
    tick();
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL echo_busy_fall: busy=%b out_valid=%b expected 0/0", busy, out_valid); end
  endtask

  task automatic test_mix(input int passes);
    logic [31:0] seeds [8];
    int cyc;
    for (int i = 0; i < 8; i++) begin seeds[i] = 32'(i); mdl[i] = seeds[i]; end
    run_model(passes);
    load_seeds(seeds, PW'(passes), 4'd0, 1'b0, 1'b0);
    wait_run(cyc, 64 * passes + 20);
    checks++; if (cyc !== 64 * passes) begin errors++; $display("FAIL mix%0d_run_cycles: got %0d expected %0d", passes, cyc, 64 * passes); end
    collect(40);
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== mdl[i]) begin errors++; $display("FAIL mix%0d_word%0d: got %h expected %h", passes, i, got[i], mdl[i]); end
    end
    checks++; if (got_last[7] !== 1'b1) begin errors++; $display("FAIL mix%0d_last: got %b expected 1", passes, got_last[7]); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mix%0d_idle: busy got %b expected 0", passes, busy); end
  endtask

  task automatic test_gapped_load(input int passes, input logic [PW-1:0] decoy);
    logic [31:0] seeds [8];
    int cyc;
    for (int i = 0; i < 8; i++) begin seeds[i] = 32'h1100_0000 + 32'(i * 17); mdl[i] = seeds[i]; end
    run_model(passes);
    load_seeds(seeds, PW'(passes), decoy, 1'b1, 1'b0);
    wait_run(cyc, 64 * passes + 20);
    checks++; if (cyc !== 64 * passes) begin errors++; $display("FAIL gap%0d_run_cycles: got %0d expected %0d", passes, cyc, 64 * passes); end
    collect(40);
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== mdl[i]) begin errors++; $display("FAIL gap%0d_word%0d: got %h expected %h", passes, i, got[i], mdl[i]); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] seeds [8];
    for (int i = 0; i < 8; i++) seeds[i] = 32'hC0C0_0000 + 32'(i);
    load_seeds(seeds, 4'd0, 4'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          checks++;
          if (out_valid !== 1'b1 || out_data !== seeds[3] || out_last !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d: valid=%b data=%h last=%b expected 1/%h/0", s, out_valid, out_data, out_last, seeds[3]);
          end
        end
        out_ready = 1'b1;
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== seeds[i] || out_last !== (i == 7)) begin
        errors++;
        $display("FAIL stall_word%0d: valid=%b data=%h last=%b expected 1/%h/%b", i, out_valid, out_data, out_last, seeds[i], (i == 7));
      end
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] seeds [8];
    for (int i = 0; i < 8; i++) seeds[i] = 32'(i);
    load_seeds(seeds, 4'd2, 4'd0, 1'b0, 1'b0);
    repeat (29) tick();
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_in_run: busy=%b out_valid=%b expected 1/0", busy, out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_in_ready: got %b expected 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0) begin errors++; $display("FAIL rst_async_out: valid=%b last=%b data=%h expected 0/0/0", out_valid, out_last, out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) seeds[i] = 32'hB000_00B0 + 32'(i);
    load_seeds(seeds, 4'd0, 4'd0, 1'b0, 1'b0);
    collect(40);
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== seeds[i]) begin errors++; $display("FAIL rst_reload_word%0d: got %h expected %h", i, got[i], seeds[i]); end
    end
    tick();
  endtask

  task automatic test_hold_valid();
    logic [31:0] seeds [8];
    int cyc = 0;
    int bad = 0;
    for (int i = 0; i < 8; i++) begin seeds[i] = 32'h1000 + 32'(i * 273); mdl[i] = seeds[i]; end
    run_model(1);
    load_seeds(seeds, 4'd1, 4'd0, 1'b0, 1'b1);
    while (!out_valid && cyc < 200) begin
      if (in_ready !== 1'b0) bad++;
      cyc++;
      tick();
    end
    checks++; if (cyc !== 64) begin errors++; $display("FAIL hold_run_cycles: got %0d expected 64", cyc); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_in_ready_run: %0d cycles with in_ready high, expected 0", bad); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready_drain: got %b expected 0", in_ready); end
    collect(40);
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== mdl[i]) begin errors++; $display("FAIL hold_word%0d: got %h expected %h", i, got[i], mdl[i]); end
    end
    tick();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_idle: busy=%b in_ready=%b expected 0/1", busy, in_ready); end
    for (int i = 0; i < 8; i++) seeds[i] = 32'h5EED_0000 + 32'(i);
    load_seeds(seeds, 4'd0, 4'd0, 1'b0, 1'b0);
    collect(40);
    for (int i = 0; i < 8; i++) begin
      checks++; if (got[i] !== seeds[i]) begin errors++; $display("FAIL hold_next_word%0d: got %h expected %h", i, got[i], seeds[i]); end
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_mix(1);
    test_mix(2);
    test_gapped_load(0, 4'd3);
    test_gapped_load(1, 4'd0);
    test_backpressure();
    test_reset_mid_run();
    test_hold_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mix_sequencer.md
MIX_SEQUENCER -- requirements
Module: mix_sequencer

Interface
REQ-001 Parameter: PASSES_W, default 4, width of cfg_passes.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  seed word present on in_data.
REQ-005 in_ready  out  1  block accepts a seed word this cycle.
REQ-006 in_data  in  32  seed word; beat k loads word k, for k = 0..7.
REQ-007 cfg_passes  in  PASSES_W  number of full mix passes; sampled on the beat that loads word 7.
REQ-008 out_valid  out  1  result word present on out_data.
REQ-009 out_ready  in  1  consumer accepts the result word.
REQ-010 out_data  out  32  result word, index 0..7 in order.
REQ-011 out_last  out  1  high with word 7.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, RUN and DRAIN, and SHALL reset to IDLE.
REQ-014 IDLE and LOAD: in_ready=1. A transfer occurs when in_valid and in_ready are both 1. The first transfer moves IDLE to LOAD. The eighth transfer moves LOAD to RUN, or to DRAIN if the sampled pass count is 0.
REQ-015 RUN: in_ready=0. The block SHALL execute exactly 64*passes cycles: stage s = 0..7 (outer loop) over word i = 0..7 (inner loop), one word update per cycle, repeated for each pass.
REQ-016 Each update SHALL read the current register contents, so words already updated in the same stage are visible. This is sequential in-place semantics.
REQ-017 All arithmetic SHALL be modulo 2^32. Indices are taken mod 8. Shifts are logical.
REQ-018 The stage update for word i SHALL be as follows:
- S0: o[i] + i
- S1: o[i] + o[i-1]
- S2: o[i] + o[i+1] - o[i+5]
- S3: o[i] ^ (o[i+3] << 16)
- S4: o[i] - (o[i+2] >> 17) + (o[i+4] >> 12)
- S5: o[i] + o[i-1] - o[i-2]
- S6: o[i]*MA[i] + CA[i]
- S7: o[i]*MB[i] + CB[i]
REQ-019 The constant tables SHALL be:
- MA = {2,3,5,7,11,13,17,19}
- CA = {3,5,7,11,13,17,19,23}
- MB = {2,3,3,3,5,13,35,87}
- CB = {0,1,8,27,64,125,216,343}
REQ-020 The cycle after the last RUN update SHALL enter DRAIN with out_valid=1, out_data=o[0] and out_last=0.
REQ-021 DRAIN: the block SHALL advance to the next word only on out_valid and out_ready. While out_ready=0, out_data and out_last SHALL hold stable. The handshake on word 7 SHALL return the FSM to IDLE on the next cycle.
REQ-022 Outside DRAIN: out_valid=0 and out_last=0. In_valid during RUN or DRAIN SHALL be ignored, and no word SHALL be consumed.
REQ-023 Pass counter overflow is impossible; the maximum run is (2^PASSES_W - 1)*64 cycles.

Reset
REQ-024 Reset asserted SHALL force, asynchronously:
- FSM to IDLE; stage, word and pass counters to 0;
- o[i] = i;
- in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0.
REQ-025 Reset during LOAD, RUN or DRAIN SHALL abandon the operation. After rst_n deasserts, the block SHALL need a full 8-beat reload.

Structure
REQ-026 Package mix_pkg SHALL hold:
- WIDTH=32 and NWORDS=8;
- MA, CA, MB and CB as constant arrays;
- the FSM state enum and the stage enum S0..S7.
REQ-027 Sub-module mix_word_alu SHALL be purely combinational. Inputs: stage, index i and o[0..7]. Output: the new o[i].
REQ-028 mix_sequencer SHALL contain the register file, counters, FSM and handshakes.

Verification
REQ-029 Passes=0, seeds 0xA0..0xA7, out_ready=1 -> out_data = 0xA0..0xA7 in order, out_last on the 8th word, busy falls 1 cycle later.
REQ-030 Passes=1, seeds 0..7 -> RUN lasts exactly 64 cycles and out words match the mix_pkg-based software model. Passes=2 -> 128 cycles and model match.
REQ-031 Load with in_valid toggling every other cycle -> exactly 8 words are captured and cfg_passes is taken from beat 8 only.
REQ-032 out_ready held 0 for 5 cycles on word 3 -> out_data stable for all 5 cycles, and no word is skipped or duplicated.
REQ-033 rst_n pulsed low at RUN cycle 30 -> outputs reach reset values immediately, and a reload with passes=0 echoes the new seeds.
REQ-034 in_valid=1 held through RUN and DRAIN -> in_ready stays 0, and the next operation loads from the first beat after IDLE.
